// File: rtl/vector_recorder.sv
// ---------------------------------------------------------------------------
// vector_recorder
//
// Captures a burst of test vectors into a small on-chip memory, then streams
// them back out over a valid/ready handshake in capture order.
//
// Session flow: IDLE -> (start) -> CAPTURE -> DRAIN -> FINISH -> IDLE.
// An empty capture (no samples written) skips DRAIN and goes to FINISH.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   start         one-cycle pulse, begins a capture session (IDLE only)
//   stop          ends the capture phase early
//   sample_in     vector to record, packed {a, b, c, y}
//   sample_valid  sample_in is valid this cycle
//   rd_data       recorded vector being streamed out
//   rd_valid      rd_data is valid (DRAIN only)
//   rd_ready      consumer accepts rd_data
//   rd_last       rd_data is the final recorded vector
//   count         number of vectors stored in the current/last session
//   busy          state is not IDLE
//   done          one-cycle pulse when a session completes
// ---------------------------------------------------------------------------
module vector_recorder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [WIDTH-1:0]         sample_in,
  input  logic                     sample_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     rd_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  // Elaboration-time guard on the geometry: the pointer arithmetic below
  // assumes a power-of-two depth of at least two entries.
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("vector_recorder: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            wr_en;

  logic [WIDTH-1:0] mem [DEPTH];

  // State and pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is deliberately not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= sample_in;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    wr_en       = 1'b0;
    rd_valid    = 1'b0;
    rd_last     = 1'b0;
    done        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = CAPTURE;
          wr_ptr_next = '0;
          rd_ptr_next = '0;
          count_next  = '0;
        end
      end

      CAPTURE: begin
        // The full check keeps a write from ever landing past the last entry,
        // even though the exit below normally leaves CAPTURE before that.
        wr_en = sample_valid && (count_reg != FULL) && !reset;
        if (wr_en) begin
          wr_ptr_next = wr_ptr_reg + ONE;
          count_next  = count_reg + ONE;
        end
        // A sample arriving together with stop is kept before leaving.
        if ((wr_en && (count_next == FULL)) || stop) begin
          state_next = (count_next != '0) ? DRAIN : FINISH;
        end
      end

      DRAIN: begin
        rd_valid = 1'b1;
        rd_last  = (rd_ptr_reg == count_reg - ONE);
        if (rd_ready) begin
          rd_ptr_next = rd_ptr_reg + ONE;
          if (rd_last) begin
            state_next = FINISH;
          end
        end
      end

      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Combinational read so the head entry is presented with no added latency.
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];
  assign count   = count_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_vector_recorder.sv
// ---------------------------------------------------------------------------
// tb_vector_recorder
//
// Self-checking bench for vector_recorder (WIDTH=4, DEPTH=16).
// A cycle-by-cycle vector table covers the basic session and the
// stop-with-sample case; hand-written sequences cover the full memory,
// backpressure, empty session and reset during DRAIN.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_vector_recorder;

  localparam int WIDTH = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             rd_last;
  logic [4:0]       count;
  logic             busy;
  logic             done;

  vector_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_last      (rd_last),
    .count        (count),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       st;
    logic       sp;
    logic       sv;
    logic [3:0] din;
    logic       rdy;
    logic       ev;
    logic [3:0] ed;
    logic       el;
    logic       eb;
    logic       edn;
    logic [4:0] ec;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];

  function automatic vec_t mk(input logic st, input logic sp, input logic sv,
                              input logic [3:0] din, input logic rdy,
                              input logic ev, input logic [3:0] ed,
                              input logic el, input logic eb, input logic edn,
                              input logic [4:0] ec);
    vec_t v;
    v.st = st; v.sp = sp; v.sv = sv; v.din = din; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = el; v.eb = eb; v.edn = edn; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start        = 1'b0;
    stop         = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    rd_ready     = 1'b0;
  endtask

  // Drains with rd_ready=1 and compares against exp_q; bounded by a cycle budget.
  task automatic drain_expect(input string tag);
    int n = 0;
    int guard = 0;
    bit got_done = 1'b0;
    rd_ready = 1'b1;
    while (guard < 64 && !got_done) begin
      @(negedge clk);
      if (rd_valid) begin
        $display("%s xfer %0d: rd_data=%h rd_last=%b", tag, n, rd_data, rd_last);
        if (n < exp_q.size()) begin
          chk({tag, "_data"}, rd_data, exp_q[n]);
          chk({tag, "_last"}, rd_last, (n == exp_q.size() - 1));
        end
        n++;
      end
      if (done) got_done = 1'b1;
      tick();
      guard++;
    end
    rd_ready = 1'b0;
    chk({tag, "_nxfers"}, n, exp_q.size());
    chk({tag, "_done_seen"}, got_done, 1'b1);
    @(negedge clk);
    chk({tag, "_count"}, count, exp_q.size());
    chk({tag, "_idle"}, busy, 1'b0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;

    // ---------------- reset state ----------------
    tick();
    @(negedge clk);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_last",  rd_last,  1'b0);
    chk("rst_busy",     busy,     1'b0);
    chk("rst_done",     done,     1'b0);
    chk("rst_count",    count,    5'd0);
    tick();
    reset = 1'b0;

    // ---------------- vector table ----------------
    //                 st sp sv din   rdy  ev ed    el eb dn count
    // Basic capture 0000,0011,0101,1001 then stop
    vecs.push_back(mk(1, 0, 0, 4'h0, 0,   0, 4'h0, 0, 0, 0, 5'd0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 0,   0, 4'h0, 0, 1, 0, 5'd0));
    vecs.push_back(mk(0, 0, 1, 4'h3, 0,   0, 4'h0, 0, 1, 0, 5'd1));
    vecs.push_back(mk(0, 0, 1, 4'h5, 0,   0, 4'h0, 0, 1, 0, 5'd2));
    vecs.push_back(mk(0, 0, 1, 4'h9, 0,   0, 4'h0, 0, 1, 0, 5'd3));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0,   0, 4'h0, 0, 1, 0, 5'd4));
    vecs.push_back(mk(0, 0, 0, 4'h0, 1,   1, 4'h0, 0, 1, 0, 5'd4));
    // start during DRAIN ignored
    vecs.push_back(mk(1, 0, 0, 4'h0, 1,   1, 4'h3, 0, 1, 0, 5'd4));
    // sample_valid during DRAIN ignored
    vecs.push_back(mk(0, 0, 1, 4'hF, 1,   1, 4'h5, 0, 1, 0, 5'd4));
    vecs.push_back(mk(0, 0, 0, 4'h0, 1,   1, 4'h9, 1, 1, 0, 5'd4));
    // FINISH: done pulse; start here is ignored
    vecs.push_back(mk(1, 0, 0, 4'h0, 0,   0, 4'h0, 0, 1, 1, 5'd4));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0,   0, 4'h0, 0, 0, 0, 5'd4));
    // Second session: stop together with sample 1110
    vecs.push_back(mk(1, 0, 0, 4'h0, 0,   0, 4'h0, 0, 0, 0, 5'd4));
    vecs.push_back(mk(0, 0, 1, 4'h7, 0,   0, 4'h0, 0, 1, 0, 5'd0));
    vecs.push_back(mk(0, 1, 1, 4'hE, 0,   0, 4'h0, 0, 1, 0, 5'd1));
    vecs.push_back(mk(0, 0, 0, 4'h0, 1,   1, 4'h7, 0, 1, 0, 5'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 1,   1, 4'hE, 1, 1, 0, 5'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0,   0, 4'h0, 0, 1, 1, 5'd2));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0,   0, 4'h0, 0, 0, 0, 5'd2));

    for (int i = 0; i < vecs.size(); i++) begin
      start        = vecs[i].st;
      stop         = vecs[i].sp;
      sample_valid = vecs[i].sv;
      sample_in    = vecs[i].din;
      rd_ready     = vecs[i].rdy;
      @(negedge clk);
      $display("row %0d: st=%b sp=%b sv=%b din=%h rdy=%b -> valid=%b data=%h last=%b busy=%b done=%b count=%0d",
               i, start, stop, sample_valid, sample_in, rd_ready,
               rd_valid, rd_data, rd_last, busy, done, count);
      chk($sformatf("row%0d_rd_valid", i), rd_valid, vecs[i].ev);
      if (vecs[i].ev) chk($sformatf("row%0d_rd_data", i), rd_data, vecs[i].ed);
      chk($sformatf("row%0d_rd_last", i), rd_last, vecs[i].el);
      chk($sformatf("row%0d_busy", i), busy, vecs[i].eb);
      chk($sformatf("row%0d_done", i), done, vecs[i].edn);
      chk($sformatf("row%0d_count", i), count, vecs[i].ec);
      tick();
    end
    clear_inputs();

    // ---------------- full memory: 20 samples, only 16 kept ----------------
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 20; k++) begin
      logic [3:0] kv;
      kv = k[3:0] ^ 4'h5;
      if (k < 16) exp_q.push_back(kv);
      sample_valid = 1'b1;
      sample_in    = kv;
      @(negedge clk);
      if (k == 15) chk("full_still_capture", rd_valid, 1'b0);
      if (k == 16) begin
        chk("full_drain_entered", rd_valid, 1'b1);
        chk("full_count16", count, 5'd16);
      end
      if (k > 16) begin
        chk($sformatf("full_count_hold%0d", k), count, 5'd16);
        chk($sformatf("full_head_hold%0d", k), rd_data, 4'h5);
      end
      tick();
    end
    clear_inputs();
    drain_expect("full");

    // ---------------- backpressure ----------------
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample_valid = 1'b1;
      sample_in    = 4'h5 + k[3:0];
      tick();
    end
    sample_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    rd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      $display("bp stall %0d: rd_valid=%b rd_data=%h", k, rd_valid, rd_data);
      chk($sformatf("bp_stall%0d_valid", k), rd_valid, 1'b1);
      chk($sformatf("bp_stall%0d_data", k), rd_data, 4'h5);
      chk($sformatf("bp_stall%0d_last", k), rd_last, 1'b0);
      tick();
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      $display("bp xfer %0d: rd_data=%h rd_last=%b", k, rd_data, rd_last);
      chk($sformatf("bp_xfer%0d_valid", k), rd_valid, 1'b1);
      chk($sformatf("bp_xfer%0d_data", k), rd_data, 4'h5 + k[3:0]);
      chk($sformatf("bp_xfer%0d_last", k), rd_last, (k == 2));
      tick();
    end
    rd_ready = 1'b0;
    @(negedge clk);
    chk("bp_done", done, 1'b1);
    chk("bp_valid_off", rd_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("bp_idle", busy, 1'b0);
    chk("bp_count", count, 5'd3);
    tick();

    // ---------------- empty session ----------------
    start = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    $display("empty: rd_valid=%b done=%b count=%0d", rd_valid, done, count);
    chk("empty_no_valid", rd_valid, 1'b0);
    chk("empty_done", done, 1'b1);
    chk("empty_count", count, 5'd0);
    tick();
    @(negedge clk);
    chk("empty_idle", busy, 1'b0);
    chk("empty_done_off", done, 1'b0);
    tick();

    // ---------------- reset during DRAIN ----------------
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sample_valid = 1'b1;
      sample_in    = 4'h9 + k[3:0];
      tick();
    end
    sample_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    rd_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      $display("rstd xfer %0d: rd_data=%h", k, rd_data);
      chk($sformatf("rstd_xfer%0d", k), rd_data, 4'h9 + k[3:0]);
      tick();
    end
    rd_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      $display("rstd post %0d: rd_valid=%b busy=%b done=%b count=%0d", k, rd_valid, busy, done, count);
      chk($sformatf("rstd_valid%0d", k), rd_valid, 1'b0);
      chk($sformatf("rstd_busy%0d", k), busy, 1'b0);
      chk($sformatf("rstd_done%0d", k), done, 1'b0);
      chk($sformatf("rstd_count%0d", k), count, 5'd0);
      tick();
    end
    rd_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.delete();
    exp_q.push_back(4'h3);
    exp_q.push_back(4'h4);
    exp_q.push_back(4'h8);
    sample_valid = 1'b1;
    sample_in = 4'h3;
    tick();
    sample_in = 4'h4;
    tick();
    sample_in = 4'h8;
    stop = 1'b1;
    tick();
    clear_inputs();
    drain_expect("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
